// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding request, a single instruction held until the core takes it.
// Latency: request accept to inst_valid is the response latency plus 1; inst handshake to next req_valid is 1.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_ebreak,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        drop;
  logic        req_pend;
  logic        inst_vld_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] cnt_q;
  logic [31:0] redir_aligned;

  assign redir_aligned = redirect_pc & ~32'h3;

  // req_pend resets to 1 so the first request appears as soon as rst drops.
  assign req_valid   = req_pend & ~rst;
  assign req_addr    = fetch_pc;
  assign inst_valid  = inst_vld_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_ebreak = inst_vld_q && (inst_q == EBREAK);
  assign fetch_cnt   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC & ~32'h3;
      drop       <= 1'b0;
      req_pend   <= 1'b1;
      inst_vld_q <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
      cnt_q      <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid)
            fetch_pc <= redir_aligned;
          if (req_ready) begin
            // A redirect in the accept cycle makes the in-flight response stale.
            drop     <= redirect_valid;
            req_pend <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            drop <= 1'b0;
            if (redirect_valid || drop) begin
              if (redirect_valid)
                fetch_pc <= redir_aligned;
              req_pend <= 1'b1;
              state    <= S_REQ;
            end else begin
              inst_q     <= rsp_data;
              inst_pc_q  <= fetch_pc;
              inst_vld_q <= 1'b1;
              state      <= S_HOLD;
            end
          end else if (redirect_valid) begin
            fetch_pc <= redir_aligned;
            drop     <= 1'b1;
          end
        end
        S_HOLD: begin
          // Redirect takes priority over a simultaneous consume.
          if (redirect_valid) begin
            fetch_pc   <= redir_aligned;
            inst_vld_q <= 1'b0;
            req_pend   <= 1'b1;
            state      <= S_REQ;
          end else if (inst_ready) begin
            fetch_pc   <= fetch_pc + 32'd4;
            cnt_q      <= cnt_q + 32'd1;
            inst_vld_q <= 1'b0;
            req_pend   <= 1'b1;
            state      <= S_REQ;
          end
        end
        default: begin
          inst_vld_q <= 1'b0;
          req_pend   <= 1'b1;
          state      <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed fetch scenarios, scoreboard queues checked by a negedge monitor.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ebreak;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_req[$];
  logic [64:0] exp_inst[$];

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ebreak    (inst_ebreak),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted request and every consumed instruction must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        n_cmp++;
        if (exp_req.size() == 0) begin
          n_err++;
          $display("FAIL req_unexpected: got addr %h expected no request", req_addr);
        end else begin
          logic [31:0] e;
          e = exp_req.pop_front();
          if (req_addr !== e) begin
            n_err++;
            $display("FAIL req_addr: got %h expected %h", req_addr, e);
          end
        end
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        n_cmp++;
        if (exp_inst.size() == 0) begin
          n_err++;
          $display("FAIL inst_unexpected: got inst %h pc %h expected none", inst, inst_pc);
        end else begin
          logic [64:0] e;
          e = exp_inst.pop_front();
          if ({inst_ebreak, inst, inst_pc} !== e) begin
            n_err++;
            $display("FAIL inst_hs: got eb=%b inst=%h pc=%h expected eb=%b inst=%h pc=%h",
                     inst_ebreak, inst, inst_pc, e[64], e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a);
    exp_req.push_back(a);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  task automatic do_rsp(input logic [31:0] d);
    rsp_valid = 1'b1;
    rsp_data  = d;
    step();
    rsp_valid = 1'b0;
  endtask

  task automatic consume(input logic [31:0] d, input logic [31:0] pc, input logic eb);
    exp_inst.push_back({eb, d, pc});
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    #3;
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'b0, req_valid}, 32'd1);
    chk("first_req_addr", req_addr, 32'h80000000);

    // Basic fetch and consume
    do_req(32'h80000000);
    do_rsp(32'h00000513);
    chk("t1_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("t1_inst_pc", inst_pc, 32'h80000000);
    consume(32'h00000513, 32'h80000000, 1'b0);
    chk("t1_next_addr", req_addr, 32'h80000004);
    chk("t1_req_valid", {31'b0, req_valid}, 32'd1);
    chk("t1_fetch_cnt", fetch_cnt, 32'd1);

    // Core stalls five cycles in HOLD
    do_req(32'h80000004);
    do_rsp(32'h12345678);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_inst", inst, 32'h12345678);
      chk("t2_inst_pc", inst_pc, 32'h80000004);
      chk("t2_no_req", {31'b0, req_valid}, 32'd0);
      chk("t2_inst_valid", {31'b0, inst_valid}, 32'd1);
    end
    consume(32'h12345678, 32'h80000004, 1'b0);
    chk("t2_fetch_cnt", fetch_cnt, 32'd2);

    // Redirect while waiting; late response dropped
    do_req(32'h80000008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000100;
    step();
    redirect_valid = 1'b0;
    step();
    do_rsp(32'hDEADBEEF);
    chk("t3_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t3_req_addr", req_addr, 32'h80000100);
    chk("t3_fetch_cnt", fetch_cnt, 32'd2);

    // ebreak detection
    do_req(32'h80000100);
    do_rsp(32'h00100073);
    chk("t4_ebreak_hold", {31'b0, inst_ebreak}, 32'd1);
    consume(32'h00100073, 32'h80000100, 1'b1);
    chk("t4_ebreak_after", {31'b0, inst_ebreak}, 32'd0);
    chk("t4_fetch_cnt", fetch_cnt, 32'd3);

    // Redirect beats inst_ready in HOLD; low address bits ignored
    do_req(32'h80000104);
    do_rsp(32'h11111111);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000022;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    chk("t5_req_addr", req_addr, 32'h80000020);
    chk("t5_fetch_cnt", fetch_cnt, 32'd3);
    chk("t5_inst_valid", {31'b0, inst_valid}, 32'd0);

    // Redirect in the accept cycle: response dropped
    exp_req.push_back(32'h80000020);
    req_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000200;
    step();
    req_ready      = 1'b0;
    redirect_valid = 1'b0;
    do_rsp(32'h44444444);
    chk("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_req_addr", req_addr, 32'h80000200);

    // Redirect in REQ without accept; stray rsp_valid ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000300;
    step();
    redirect_valid = 1'b0;
    chk("t7_req_addr", req_addr, 32'h80000300);
    do_rsp(32'h55555555);
    chk("t7_req_valid", {31'b0, req_valid}, 32'd1);
    chk("t7_inst_valid", {31'b0, inst_valid}, 32'd0);

    // Redirect with response in the same WAIT cycle; next fetch not dropped
    do_req(32'h80000300);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000400;
    rsp_valid      = 1'b1;
    rsp_data       = 32'h66666666;
    step();
    redirect_valid = 1'b0;
    rsp_valid      = 1'b0;
    chk("t8_req_addr", req_addr, 32'h80000400);
    chk("t8_inst_valid", {31'b0, inst_valid}, 32'd0);
    do_req(32'h80000400);
    do_rsp(32'h00000ABC);
    chk("t8_hold", {31'b0, inst_valid}, 32'd1);
    consume(32'h00000ABC, 32'h80000400, 1'b0);
    chk("t8_fetch_cnt", fetch_cnt, 32'd4);

    // fetch_pc wraps at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFE;
    step();
    redirect_valid = 1'b0;
    do_req(32'hFFFFFFFC);
    do_rsp(32'h00000022);
    consume(32'h00000022, 32'hFFFFFFFC, 1'b0);
    chk("t9_wrap_addr", req_addr, 32'h00000000);
    chk("t9_fetch_cnt", fetch_cnt, 32'd5);

    // Asynchronous reset mid-WAIT; late response ignored
    do_req(32'h00000000);
    rst = 1'b1;
    #1;
    chk("t10_async_req_valid", {31'b0, req_valid}, 32'd0);
    chk("t10_async_fetch_cnt", fetch_cnt, 32'd0);
    step();
    rst = 1'b0;
    do_rsp(32'h33333333);
    chk("t10_req_valid", {31'b0, req_valid}, 32'd1);
    chk("t10_req_addr", req_addr, 32'h80000000);
    chk("t10_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t10_inst", inst, 32'd0);
    chk("t10_inst_pc", inst_pc, 32'd0);
    chk("t10_ebreak", {31'b0, inst_ebreak}, 32'd0);
    chk("t10_fetch_cnt", fetch_cnt, 32'd0);

    step();
    chk("req_queue_drained", exp_req.size(), 32'd0);
    chk("inst_queue_drained", exp_inst.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
